rvlab_jtag_seq: RTL and testbench

Synthesizable, parametrised JTAG master sequencer that runs TAP reset, IR scans, DR scans and idle clocking from a valid/ready command stream. It drives TCK/TMS/TDI, samples TDO and returns captured scan data on a valid/ready response stream. It sits between an on-chip test controller (or a bench-side command source) and the rvlab TAP / RISC-V debug transport.

---
 rtl/rvlab_jtag_seq_pkg.sv | 41 ++++
 rtl/rvlab_jtag_tck_gen.sv | 42 ++++
 rtl/rvlab_jtag_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_rvlab_jtag_seq.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvlab_jtag_seq_pkg.sv
// Shared types and TMS sequence constants for the JTAG master sequencer.
package rvlab_jtag_seq_pkg;

    // Command operations carried on cmd_op_i
    typedef enum logic [1:0] {
        OP_RESET = 2'd0,
        OP_IR    = 2'd1,
        OP_DR    = 2'd2,
        OP_IDLE  = 2'd3
    } jtag_op_e;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        S_READY,
        S_RST,
        S_PRE,
        S_SHIFT,
        S_POST,
        S_IDLECLK,
        S_RSP
    } seq_state_e;

    // TMS patterns are consumed LSB first, one bit per TCK.
    // Reset: 1,1,1,1,1,0 -> Test-Logic-Reset then Run-Test/Idle.
    localparam logic [5:0] RESET_TMS = 6'b011111;
    localparam logic [2:0] RESET_LEN = 3'd6;
    // IR entry from Run-Test/Idle: 1,1,0,0 -> Shift-IR.
    localparam logic [5:0] IR_PRE_TMS = 6'b000011;
    localparam logic [2:0] IR_PRE_LEN = 3'd4;
    // DR entry from Run-Test/Idle: 1,0,0 -> Shift-DR.
    localparam logic [5:0] DR_PRE_TMS = 6'b000001;
    localparam logic [2:0] DR_PRE_LEN = 3'd3;
    // Exit: Exit1 -> Update (TMS 1) -> Run-Test/Idle (TMS 0).
    localparam logic [2:0] POST_LEN = 3'd2;

    // Every op except a TAP reset needs the TAP in a known state
    function automatic logic needs_known_tap(input jtag_op_e op);
        return op != OP_RESET;
    endfunction

endpackage

// File: rtl/rvlab_jtag_tck_gen.sv
// TCK divider: low phase of ClkDiv cycles followed by a high phase of
// ClkDiv cycles. fall_stb marks the edge that starts each low phase
// (including the first one after enable), rise_stb the edge where TCK rises.
module rvlab_jtag_tck_gen #(
    parameter int unsigned ClkDiv = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en,
    output logic tck,
    output logic fall_stb,
    output logic rise_stb
);

    localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(2 * ClkDiv) : 1;
    localparam logic [CntW-1:0] RiseAt = CntW'(ClkDiv);
    localparam logic [CntW-1:0] WrapAt = CntW'(2 * ClkDiv - 1);

    logic [CntW-1:0] cnt;

    assign fall_stb = en && (cnt == '0);
    assign rise_stb = en && (cnt == RiseAt);

    // Phase counter and TCK level; parked low and at phase 0 while disabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= (cnt == WrapAt) ? '0 : cnt + 1'b1;
            if (rise_stb) begin
                tck <= 1'b1;
            end else if (fall_stb) begin
                tck <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rvlab_jtag_seq.sv
// JTAG master sequencer: turns reset / IR / DR / idle commands into
// TCK/TMS/TDI activity and returns captured TDO bits as one response
// per command.
module rvlab_jtag_seq
    import rvlab_jtag_seq_pkg::*;
#(
    parameter int unsigned IrWidth    = 5,
    parameter int unsigned DrMaxWidth = 64,
    parameter int unsigned ClkDiv     = 4,
    parameter int unsigned LenWidth   = $clog2(DrMaxWidth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [LenWidth-1:0]   cmd_len_i,
    input  logic [DrMaxWidth-1:0] cmd_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DrMaxWidth-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic                  jtag_tck_o,
    output logic                  jtag_tms_o,
    output logic                  jtag_tdi_o,
    input  logic                  jtag_tdo_i
);

    localparam logic [LenWidth-1:0] MaxLen = LenWidth'(DrMaxWidth);
    localparam logic [LenWidth-1:0] IrLen  = LenWidth'(IrWidth);
    localparam logic [LenWidth-1:0] OneLen = LenWidth'(1);

    seq_state_e             state;
    jtag_op_e               cmd_op;
    logic                   cmd_err;
    logic                   tap_known;
    logic                   err_q;
    logic [5:0]             tms_pat;
    logic [2:0]             seq_cnt;
    logic [2:0]             seq_len;
    logic [LenWidth-1:0]    shift_cnt;
    logic [LenWidth-1:0]    scan_len;
    logic [DrMaxWidth-1:0]  sh_in;
    logic [DrMaxWidth-1:0]  cap;
    logic [DrMaxWidth-1:0]  cap_mask;
    logic                   tck_en;
    logic                   tck;
    logic                   fall_stb;
    logic                   rise_stb;

    assign cmd_op     = jtag_op_e'(cmd_op_i);
    assign tck_en     = (state != S_READY) && (state != S_RSP);
    assign jtag_tck_o = tck;

    rvlab_jtag_tck_gen #(
        .ClkDiv (ClkDiv)
    ) u_tck_gen (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .en       (tck_en),
        .tck      (tck),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

    // Reject commands that would need an unknown TAP or an out-of-range DR length
    always_comb begin
        cmd_err = 1'b0;
        if (needs_known_tap(cmd_op) && !tap_known) begin
            cmd_err = 1'b1;
        end
        if ((cmd_op == OP_DR) && ((cmd_len_i == '0) || (cmd_len_i > MaxLen))) begin
            cmd_err = 1'b1;
        end
    end

    // Command sequencing FSM: TMS/TDI are updated on fall_stb, TDO captured on rise_stb
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_READY;
            tap_known   <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_data_o  <= '0;
            jtag_tms_o  <= 1'b1;
            jtag_tdi_o  <= 1'b0;
            tms_pat     <= '0;
            seq_cnt     <= '0;
            seq_len     <= '0;
            shift_cnt   <= '0;
            scan_len    <= '0;
            sh_in       <= '0;
            cap         <= '0;
            cap_mask    <= '0;
        end else begin
            case (state)
                S_READY: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        err_q       <= cmd_err;
                        sh_in       <= cmd_data_i;
                        cap         <= '0;
                        cap_mask    <= {{(DrMaxWidth-1){1'b0}}, 1'b1};
                        seq_cnt     <= '0;
                        shift_cnt   <= '0;
                        scan_len    <= cmd_len_i;
                        if (cmd_err) begin
                            state <= S_RSP;
                        end else begin
                            case (cmd_op)
                                OP_RESET: begin
                                    tms_pat <= RESET_TMS;
                                    seq_len <= RESET_LEN;
                                    state   <= S_RST;
                                end
                                OP_IR: begin
                                    tms_pat  <= IR_PRE_TMS;
                                    seq_len  <= IR_PRE_LEN;
                                    scan_len <= IrLen;
                                    state    <= S_PRE;
                                end
                                OP_DR: begin
                                    tms_pat <= DR_PRE_TMS;
                                    seq_len <= DR_PRE_LEN;
                                    state   <= S_PRE;
                                end
                                default: begin
                                    // Zero-length idle answers without any TCK
                                    state <= (cmd_len_i == '0) ? S_RSP : S_IDLECLK;
                                end
                            endcase
                        end
                    end
                end

                S_RST: begin
                    if (fall_stb) begin
                        if (seq_cnt == seq_len) begin
                            tap_known   <= 1'b1;
                            state       <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_data_o  <= '0;
                            jtag_tms_o  <= 1'b0;
                        end else begin
                            jtag_tms_o <= tms_pat[0];
                            tms_pat    <= tms_pat >> 1;
                            seq_cnt    <= seq_cnt + 1'b1;
                        end
                    end
                end

                S_PRE: begin
                    if (fall_stb) begin
                        if (seq_cnt == seq_len) begin
                            // Entry done: this low phase already carries shift bit 0
                            state      <= S_SHIFT;
                            jtag_tms_o <= (scan_len == OneLen);
                            jtag_tdi_o <= sh_in[0];
                            sh_in      <= sh_in >> 1;
                            shift_cnt  <= OneLen;
                        end else begin
                            jtag_tms_o <= tms_pat[0];
                            tms_pat    <= tms_pat >> 1;
                            seq_cnt    <= seq_cnt + 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (rise_stb) begin
                        if (jtag_tdo_i) begin
                            cap <= cap | cap_mask;
                        end
                        cap_mask <= cap_mask << 1;
                    end
                    if (fall_stb) begin
                        if (shift_cnt == scan_len) begin
                            // Last shift TCK already moved the TAP to Exit1
                            state      <= S_POST;
                            jtag_tms_o <= 1'b1;
                            jtag_tdi_o <= 1'b0;
                            seq_cnt    <= 3'd1;
                            seq_len    <= POST_LEN;
                        end else begin
                            jtag_tms_o <= ((shift_cnt + 1'b1) == scan_len);
                            jtag_tdi_o <= sh_in[0];
                            sh_in      <= sh_in >> 1;
                            shift_cnt  <= shift_cnt + 1'b1;
                        end
                    end
                end

                S_POST: begin
                    if (fall_stb) begin
                        if (seq_cnt == seq_len) begin
                            state       <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_data_o  <= cap;
                            jtag_tms_o  <= 1'b0;
                        end else begin
                            jtag_tms_o <= 1'b0;
                            seq_cnt    <= seq_cnt + 1'b1;
                        end
                    end
                end

                S_IDLECLK: begin
                    if (fall_stb) begin
                        if (shift_cnt == scan_len) begin
                            state       <= S_RSP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_data_o  <= '0;
                        end else begin
                            jtag_tms_o <= 1'b0;
                            shift_cnt  <= shift_cnt + 1'b1;
                        end
                    end
                end

                S_RSP: begin
                    if (!rsp_valid_o) begin
                        // Immediate answer path: error or zero-length idle
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= err_q;
                        rsp_data_o  <= '0;
                    end else if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rsp_err_o   <= 1'b0;
                        busy_o      <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state       <= S_READY;
                    end
                end

                default: begin
                    state <= S_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvlab_jtag_seq.sv
// Directed bench for rvlab_jtag_seq with a behavioural TAP (IDCODE 32'h1 on IR 5'h1,
// bypass on any other IR) and ClkDiv=2.
module tb_rvlab_jtag_seq;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [6:0]    cmd_len = 7'd0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic          tck, tms, tdi, tdo;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int tck_cnt = 0;
    logic [63:0] tms_hist = '0;

    rvlab_jtag_seq #(
        .IrWidth(5), .DrMaxWidth(DW), .ClkDiv(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy),
        .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi), .jtag_tdo_i(tdo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge tck) begin
        tck_cnt  <= tck_cnt + 1;
        tms_hist <= {tms_hist[62:0], tms};
    end

    // Behavioural TAP
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    tap_e        tap_st = TLR;
    logic [4:0]  ir = 5'h1;
    logic [4:0]  ir_sh = 5'h0;
    logic [31:0] id_sh = 32'h0;
    logic        byp = 1'b0;

    function automatic tap_e tap_next(input tap_e s, input logic m);
        case (s)
            TLR:     return m ? TLR : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap_st)
            TLR:    ir <= 5'h1;
            CAP_DR: if (ir == 5'h1) id_sh <= 32'h1; else byp <= 1'b0;
            SH_DR:  if (ir == 5'h1) id_sh <= {tdi, id_sh[31:1]}; else byp <= tdi;
            CAP_IR: ir_sh <= 5'b00001;
            SH_IR:  ir_sh <= {tdi, ir_sh[4:1]};
            UPD_IR: ir <= ir_sh;
            default: ;
        endcase
        tap_st <= tap_next(tap_st, tms);
    end

    assign tdo = (tap_st == SH_DR) ? ((ir == 5'h1) ? id_sh[0] : byp)
               : (tap_st == SH_IR) ? ir_sh[0] : 1'b0;

    // Present a command and return the accept edge number and TCK count at accept
    task automatic send_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                            output int k, output int t0);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        t0 = tck_cnt;
        @(posedge clk);
        #1;
        k = cyc;
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response; lat stays -1 if none arrives
    task automatic wait_rsp(input int k, input int t0, output logic [63:0] d, output logic e,
                            output int lat, output int ntck);
        lat = -1;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = cyc - k;
                break;
            end
        end
        d = rsp_data;
        e = rsp_err;
        ntck = tck_cnt - t0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data,
                           output logic [63:0] d, output logic e, output int lat, output int ntck);
        int k, t0;
        send_cmd(op, len, data, k, t0);
        wait_rsp(k, t0, d, e, lat, ntck);
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi} !== 7'b1000010) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 1000010",
                     {cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi});
        end
        checks++;
        if (rsp_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_not_reset();
        logic [63:0] d; logic e; int lat, n;
        run_cmd(2'd2, 7'd32, 64'h0, d, e, lat, n);
        checks++;
        if ({e, d} !== {1'b1, 64'h0}) begin
            errors++;
            $display("FAIL unknown_tap_err: got err=%b data=%h expected err=1 data=0", e, d);
        end
        checks++;
        if (lat != 1 || n != 0) begin
            errors++;
            $display("FAIL unknown_tap_timing: got lat=%0d tcks=%0d expected lat=1 tcks=0", lat, n);
        end
        ack_rsp();
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL after_ack: got ready/busy/valid=%b expected 100", {cmd_ready, busy, rsp_valid});
        end
    endtask

    task automatic test_tap_reset();
        logic [63:0] d; logic e; int lat, n;
        run_cmd(2'd0, 7'd0, 64'h0, d, e, lat, n);
        checks++;
        if (lat != 25 || n != 6) begin
            errors++;
            $display("FAIL tap_reset_timing: got lat=%0d tcks=%0d expected lat=25 tcks=6", lat, n);
        end
        checks++;
        if (tms_hist[5:0] !== 6'b111110) begin
            errors++;
            $display("FAIL tap_reset_tms: got %b expected 111110", tms_hist[5:0]);
        end
        checks++;
        if ({e, d} !== 65'h0 || tap_st != RTI || {tck, tms} !== 2'b00) begin
            errors++;
            $display("FAIL tap_reset_rsp: got err=%b data=%h tap=%0d tck/tms=%b expected 0 0 RTI 00",
                     e, d, tap_st, {tck, tms});
        end
        ack_rsp();
    endtask

    task automatic test_idcode();
        logic [63:0] d; logic e; int lat, n;
        run_cmd(2'd1, 7'd0, 64'h1, d, e, lat, n);
        checks++;
        if (lat != 45 || n != 11) begin
            errors++;
            $display("FAIL ir_timing: got lat=%0d tcks=%0d expected lat=45 tcks=11", lat, n);
        end
        checks++;
        if (tms_hist[10:0] !== 11'b11000000110) begin
            errors++;
            $display("FAIL ir_tms: got %b expected 11000000110", tms_hist[10:0]);
        end
        checks++;
        if ({e, d} !== {1'b0, 64'h1} || ir !== 5'h1) begin
            errors++;
            $display("FAIL ir_rsp: got err=%b data=%h ir=%h expected 0 1 01", e, d, ir);
        end
        ack_rsp();
        run_cmd(2'd2, 7'd32, 64'h0, d, e, lat, n);
        checks++;
        if (lat != 149 || n != 37) begin
            errors++;
            $display("FAIL idcode_timing: got lat=%0d tcks=%0d expected lat=149 tcks=37", lat, n);
        end
        checks++;
        if ({e, d} !== {1'b0, 64'h00000001}) begin
            errors++;
            $display("FAIL idcode_data: got err=%b data=%h expected 0 00000001", e, d);
        end
        ack_rsp();
    endtask

    task automatic test_loopback_bounds();
        logic [63:0] d; logic e; int lat, n;
        run_cmd(2'd1, 7'd0, 64'h1F, d, e, lat, n);
        checks++;
        if (ir !== 5'h1F || d !== 64'h1) begin
            errors++;
            $display("FAIL bypass_ir: got ir=%h data=%h expected 1f 1", ir, d);
        end
        ack_rsp();
        run_cmd(2'd2, 7'd64, 64'hDEADBEEF_01234567, d, e, lat, n);
        checks++;
        if ({e, d} !== {1'b0, 64'hBD5B7DDE_02468ACE}) begin
            errors++;
            $display("FAIL loop64_data: got err=%b data=%h expected 0 bd5b7dde02468ace", e, d);
        end
        checks++;
        if (lat != 277 || n != 69) begin
            errors++;
            $display("FAIL loop64_timing: got lat=%0d tcks=%0d expected lat=277 tcks=69", lat, n);
        end
        ack_rsp();
        run_cmd(2'd2, 7'd8, 64'hFFFF_FFFF_FFFF_FFA5, d, e, lat, n);
        checks++;
        if ({e, d} !== {1'b0, 64'h4A} || lat != 53) begin
            errors++;
            $display("FAIL loop8: got err=%b data=%h lat=%0d expected 0 4a 53", e, d, lat);
        end
        ack_rsp();
        run_cmd(2'd2, 7'd0, 64'h5, d, e, lat, n);
        checks++;
        if ({e, d} !== {1'b1, 64'h0} || lat != 1 || n != 0) begin
            errors++;
            $display("FAIL dr_len0: got err=%b data=%h lat=%0d tcks=%0d expected 1 0 1 0", e, d, lat, n);
        end
        ack_rsp();
        run_cmd(2'd2, 7'd65, 64'h5, d, e, lat, n);
        checks++;
        if ({e, d} !== {1'b1, 64'h0} || lat != 1 || n != 0) begin
            errors++;
            $display("FAIL dr_len65: got err=%b data=%h lat=%0d tcks=%0d expected 1 0 1 0", e, d, lat, n);
        end
        ack_rsp();
    endtask

    task automatic test_idle();
        logic [63:0] d; logic e; int lat, n;
        run_cmd(2'd3, 7'd3, 64'hFF, d, e, lat, n);
        checks++;
        if (lat != 13 || n != 3 || tms_hist[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL idle3: got lat=%0d tcks=%0d tms=%b expected 13 3 000", lat, n, tms_hist[2:0]);
        end
        checks++;
        if ({e, d} !== 65'h0) begin
            errors++;
            $display("FAIL idle3_rsp: got err=%b data=%h expected 0 0", e, d);
        end
        ack_rsp();
        run_cmd(2'd3, 7'd0, 64'hFF, d, e, lat, n);
        checks++;
        if ({e, d} !== 65'h0 || lat != 1 || n != 0) begin
            errors++;
            $display("FAIL idle0: got err=%b data=%h lat=%0d tcks=%0d expected 0 0 1 0", e, d, lat, n);
        end
        ack_rsp();
    endtask

    task automatic test_backpressure();
        logic [63:0] d; logic e; int lat, n, t1, bad;
        run_cmd(2'd2, 7'd8, 64'hA5, d, e, lat, n);
        t1 = tck_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_data !== 64'h4A || rsp_err !== 1'b0 ||
                cmd_ready !== 1'b0 || busy !== 1'b1 || tck_cnt != t1 || tck !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
        end
        ack_rsp();
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL backpressure_release: got ready/busy/valid=%b expected 100",
                     {cmd_ready, busy, rsp_valid});
        end
    endtask

    task automatic test_mid_reset();
        logic [63:0] d; logic e; int lat, n, k, t0, t1, seen;
        send_cmd(2'd2, 7'd40, 64'h0F0F, k, t0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi} !== 7'b1000010 || rsp_data !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b data=%h expected 1000010 0",
                     {cmd_ready, rsp_valid, rsp_err, busy, tck, tms, tdi}, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t1 = tck_cnt;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0 || tck_cnt != t1) begin
            errors++;
            $display("FAIL mid_reset_drop: got rsp cycles=%0d tcks=%0d expected 0 0", seen, tck_cnt - t1);
        end
        run_cmd(2'd1, 7'd0, 64'h1, d, e, lat, n);
        checks++;
        if ({e, d} !== {1'b1, 64'h0} || lat != 1 || n != 0) begin
            errors++;
            $display("FAIL mid_reset_ir_reject: got err=%b data=%h lat=%0d tcks=%0d expected 1 0 1 0",
                     e, d, lat, n);
        end
        ack_rsp();
    endtask

    initial begin
        test_reset();
        test_not_reset();
        test_tap_reset();
        test_idcode();
        test_loopback_bounds();
        test_idle();
        test_backpressure();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
